// File: rtl/mux16_arbiter_if.sv
// rtl/mux16_arbiter_if.sv - two-requester stream bundle plus arbiter status lines
interface mux16_arbiter_if;
    logic        a_valid;
    logic [15:0] a_data;
    logic        a_last;
    logic        a_ready;
    logic        b_valid;
    logic [15:0] b_data;
    logic        b_last;
    logic        b_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_last;
    logic        out_ready;
    logic        sel;
    logic        busy;
    logic        overrun;

    modport slave (
        input  a_valid, a_data, a_last, b_valid, b_data, b_last, out_ready,
        output a_ready, b_ready, out_valid, out_data, out_last, sel, busy, overrun
    );

    modport master (
        output a_valid, a_data, a_last, b_valid, b_data, b_last, out_ready,
        input  a_ready, b_ready, out_valid, out_data, out_last, sel, busy, overrun
    );
endinterface

// File: rtl/mux16_arbiter.sv
// rtl/mux16_arbiter.sv - round-robin packet arbiter steering a 16-bit 2:1 stream mux
module mux16_arbiter #(
    parameter  int MAX_BEATS = 16,
    localparam int CNT_W     = $clog2(MAX_BEATS)
) (
    input  logic             clk,
    input  logic             rst_n,
    mux16_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BEATS - 1);

    state_t           state_q, state_d;
    logic             last_a_q, last_a_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             overrun_q, overrun_d;

    logic own_a, own_b, busy, x_valid, x_last, at_cap, out_valid, beat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_a_q   <= 1'b0;
            beat_cnt_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_a_q   <= last_a_d;
            beat_cnt_q <= beat_cnt_d;
            overrun_q  <= overrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_a_d   = last_a_q;
        beat_cnt_d = beat_cnt_q;
        overrun_d  = 1'b0;

        own_a     = (state_q == OWN_A);
        own_b     = (state_q == OWN_B);
        busy      = own_a | own_b;
        x_valid   = own_a ? bus.a_valid : bus.b_valid;
        x_last    = own_a ? bus.a_last  : bus.b_last;
        at_cap    = (beat_cnt_q == LAST_BEAT);
        out_valid = busy & x_valid;
        beat      = out_valid & bus.out_ready;

        case (state_q)
            IDLE: begin
                // On a tie the grant goes to whichever side did not win last time
                if (bus.a_valid && (!bus.b_valid || !last_a_q)) begin
                    state_d = OWN_A;
                end else if (bus.b_valid) begin
                    state_d = OWN_B;
                end
            end
            OWN_A, OWN_B: begin
                if (beat) begin
                    if (x_last || at_cap) begin
                        state_d    = IDLE;
                        last_a_d   = own_a;
                        beat_cnt_d = '0;
                        overrun_d  = !x_last;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.sel       = own_a;
    assign bus.busy      = busy;
    assign bus.out_valid = out_valid;
    assign bus.a_ready   = own_a & bus.out_ready;
    assign bus.b_ready   = own_b & bus.out_ready;
    assign bus.out_last  = busy & (x_last | at_cap);
    assign bus.out_data  = own_a ? bus.a_data : bus.b_data;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_mux16_arbiter.sv
// tb/tb_mux16_arbiter.sv - cycle vector table plus beat scoreboard for mux16_arbiter
module tb_mux16_arbiter;

    typedef struct {
        logic        rst_n;
        logic        av;
        logic [15:0] ad;
        logic        al;
        logic        bv;
        logic [15:0] bd;
        logic        bl;
        logic        ordy;
        logic [6:0]  exp_flags;
        logic [15:0] exp_data;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        logic        last;
        logic        sel;
        int          cyc;
    } word_t;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    vec_t  vecs[$];
    vec_t  exp_q[$];
    word_t wq[$];

    mux16_arbiter_if ifc ();

    mux16_arbiter #(.MAX_BEATS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic av, input logic [15:0] ad, input logic al,
                                input logic bv, input logic [15:0] bd, input logic bl, input logic ordy,
                                input logic [6:0] ef, input logic [15:0] ed);
        vec_t v;
        v.rst_n = r;  v.av = av; v.ad = ad; v.al = al;
        v.bv = bv;    v.bd = bd; v.bl = bl; v.ordy = ordy;
        v.exp_flags = ef; v.exp_data = ed;
        return v;
    endfunction

    task automatic push_pkt(input logic [15:0] base, input int len, input logic s,
                            input int start, input int stride);
        word_t w;
        for (int i = 0; i < len; i++) begin
            w.data = base + 16'(i);
            w.last = (i == len - 1);
            w.sel  = s;
            w.cyc  = start + i * stride;
            wq.push_back(w);
        end
    endtask

    task automatic drive_idle_inputs();
        ifc.a_valid = 1'b0; ifc.a_data = 16'h0; ifc.a_last = 1'b0;
        ifc.b_valid = 1'b0; ifc.b_data = 16'h0; ifc.b_last = 1'b0;
        ifc.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive_idle_inputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic run_seq(input string name, input int ncyc, input int alen, input int blen,
                           input bit toggle);
        int    ai = 0;
        int    bi = 0;
        word_t w;
        logic [15:0] a_got, a_exp;
        for (int c = 0; c < ncyc; c++) begin
            ifc.a_valid   = (alen > 0);
            ifc.a_data    = 16'hA000 + 16'(ai);
            ifc.a_last    = (ai == alen - 1);
            ifc.b_valid   = (blen > 0);
            ifc.b_data    = 16'hB000 + 16'(bi);
            ifc.b_last    = (bi == blen - 1);
            ifc.out_ready = toggle ? ((c % 2) == 1) : 1'b1;
            @(negedge clk);
            if (alen == 0 || !ifc.out_ready) begin
                tests++;
                if (ifc.a_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL %s a_ready cyc %0d: got %b want 0", name, c, ifc.a_ready);
                end
            end
            if (ifc.out_valid && ifc.out_ready) begin
                tests++;
                if (wq.size() == 0) begin
                    fails++;
                    $display("FAIL %s extra beat cyc %0d: got data %h, want none", name, c, ifc.out_data);
                end else begin
                    w = wq.pop_front();
                    a_got = ifc.out_data;
                    a_exp = w.data;
                    if (a_got !== a_exp || ifc.out_last !== w.last || ifc.sel !== w.sel || c != w.cyc) begin
                        fails++;
                        $display("FAIL %s beat: got data %h last %b sel %b cyc %0d, want data %h last %b sel %b cyc %0d",
                                 name, a_got, ifc.out_last, ifc.sel, c, a_exp, w.last, w.sel, w.cyc);
                    end
                end
            end
            if (ifc.a_valid && ifc.a_ready) ai = (ai == alen - 1) ? 0 : ai + 1;
            if (ifc.b_valid && ifc.b_ready) bi = (bi == blen - 1) ? 0 : bi + 1;
            @(posedge clk); #1;
        end
        tests++;
        if (wq.size() != 0) begin
            fails++;
            $display("FAIL %s missing beats: got %0d left, want 0", name, wq.size());
            wq.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        v;
        logic [6:0]  got_f;
        rst_n = 1'b0;
        drive_idle_inputs();

        // flags = {sel, busy, out_valid, a_ready, b_ready, out_last, overrun}
        vecs.push_back(mk(0,1,16'h1234,1,0,16'h0000,0,1, 7'b0000000,16'h0000));
        vecs.push_back(mk(1,1,16'h1234,1,0,16'h0000,0,1, 7'b0000000,16'h0000));
        vecs.push_back(mk(1,1,16'h1234,1,0,16'h0000,0,1, 7'b1111010,16'h1234));
        vecs.push_back(mk(1,0,16'h1234,1,0,16'h0000,0,1, 7'b0000000,16'h0000));
        // A overruns the 4-beat cap while B waits
        vecs.push_back(mk(1,1,16'hA000,0,0,16'hB000,1,1, 7'b0000000,16'hB000));
        vecs.push_back(mk(1,1,16'hA000,0,1,16'hB000,1,1, 7'b1111000,16'hA000));
        vecs.push_back(mk(1,1,16'hA001,0,1,16'hB000,1,1, 7'b1111000,16'hA001));
        vecs.push_back(mk(1,1,16'hA002,0,1,16'hB000,1,1, 7'b1111000,16'hA002));
        vecs.push_back(mk(1,1,16'hA003,0,1,16'hB000,1,1, 7'b1111010,16'hA003));
        vecs.push_back(mk(1,1,16'hA004,0,1,16'hB000,1,1, 7'b0000001,16'hB000));
        vecs.push_back(mk(1,1,16'hA004,0,1,16'hB000,1,1, 7'b0110110,16'hB000));
        vecs.push_back(mk(1,1,16'hA004,0,0,16'hB000,1,1, 7'b0000000,16'hB000));
        vecs.push_back(mk(1,1,16'hA004,0,0,16'hB000,1,1, 7'b1111000,16'hA004));
        vecs.push_back(mk(1,1,16'hA005,1,0,16'hB000,1,1, 7'b1111010,16'hA005));
        vecs.push_back(mk(1,0,16'hA005,1,0,16'hB000,1,1, 7'b0000000,16'hB000));
        // reset lands on beat 2 of a B packet; the next tie must go to A
        vecs.push_back(mk(1,0,16'hA000,1,1,16'hB000,0,1, 7'b0000000,16'hB000));
        vecs.push_back(mk(1,0,16'hA000,1,1,16'hB000,0,1, 7'b0110100,16'hB000));
        vecs.push_back(mk(0,1,16'hA000,1,1,16'hB001,0,1, 7'b0000000,16'hB001));
        vecs.push_back(mk(1,1,16'hA000,1,1,16'hB001,0,1, 7'b0000000,16'hB001));
        vecs.push_back(mk(1,1,16'hA000,1,1,16'hB001,0,1, 7'b1111010,16'hA000));
        vecs.push_back(mk(1,0,16'hA000,1,0,16'hB001,0,1, 7'b0000000,16'hB001));

        @(posedge clk); #1;
        for (int i = 0; i < vecs.size(); i++) begin
            rst_n         = vecs[i].rst_n;
            ifc.a_valid   = vecs[i].av;
            ifc.a_data    = vecs[i].ad;
            ifc.a_last    = vecs[i].al;
            ifc.b_valid   = vecs[i].bv;
            ifc.b_data    = vecs[i].bd;
            ifc.b_last    = vecs[i].bl;
            ifc.out_ready = vecs[i].ordy;
            exp_q.push_back(vecs[i]);
            @(negedge clk);
            v = exp_q.pop_front();
            got_f = {ifc.sel, ifc.busy, ifc.out_valid, ifc.a_ready, ifc.b_ready, ifc.out_last, ifc.overrun};
            tests++;
            if (got_f !== v.exp_flags || ifc.out_data !== v.exp_data) begin
                fails++;
                $display("FAIL vec%0d: got flags %b data %h, want flags %b data %h",
                         i, got_f, ifc.out_data, v.exp_flags, v.exp_data);
            end
            @(posedge clk); #1;
        end

        do_reset();
        push_pkt(16'hA000, 3, 1'b1, 1, 1);
        push_pkt(16'hB000, 3, 1'b0, 5, 1);
        push_pkt(16'hA000, 3, 1'b1, 9, 1);
        run_seq("fair", 12, 3, 3, 1'b0);

        do_reset();
        push_pkt(16'hA000, 4, 1'b1, 1, 2);
        run_seq("stall", 9, 4, 0, 1'b1);

        do_reset();
        push_pkt(16'hB000, 2, 1'b0, 1, 1);
        push_pkt(16'hB000, 2, 1'b0, 4, 1);
        push_pkt(16'hB000, 2, 1'b0, 7, 1);
        run_seq("bonly", 9, 0, 2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
